// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard interface: instruction descriptor in, stall/bypass/forward controls out.
// The pipeline control side uses "master"; the hazard unit uses "slave".
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      id_valid;
  logic                      id_flush;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic                      id_is_branch;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_mem_read;

  logic                      stall;
  logic [1:0]                id_fwd_a_sel;
  logic [1:0]                id_fwd_b_sel;
  logic                      is_MEM_forward_ALU_A;
  logic                      is_MEM_forward_ALU_B;

  modport master (
    output id_valid, id_flush, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_is_branch, id_rd, id_reg_write, id_mem_read,
    input  stall, id_fwd_a_sel, id_fwd_b_sel,
           is_MEM_forward_ALU_A, is_MEM_forward_ALU_B
  );

  modport slave (
    input  id_valid, id_flush, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_is_branch, id_rd, id_reg_write, id_mem_read,
    output stall, id_fwd_a_sel, id_fwd_b_sel,
           is_MEM_forward_ALU_A, is_MEM_forward_ALU_B
  );

endinterface

// File: rtl/hazard_forward_unit.sv
// RAW hazard detection for the ID instruction against shadow copies of the EX and MEM stages;
// resolves each hazard with an ID bypass, an EX-stage load forward, or a single bubble.
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave bus
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EX_ALU  = 2'b01;
  localparam logic [1:0] SEL_MEM_WB  = 2'b10;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } shadow_t;

  shadow_t    r_ex;
  shadow_t    r_mem;
  logic       r_fwd_a;
  logic       r_fwd_b;

  logic       w_live;
  logic       w_m1;
  logic       w_m2;
  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic       w_mem_hit_a;
  logic       w_mem_hit_b;
  logic       w_stall;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  shadow_t    w_ex_next;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic is_producer(shadow_t e, reg_addr_t r);
    return e.valid && e.reg_write && (e.rd == r) && (r != '0);
  endfunction

  // Loads in EX are left to the EX-stage DM forward; branches resolve in ID and
  // cannot consume an EX ALU result in the same cycle, so they stall instead.
  function automatic logic [1:0] operand_sel(logic stall, logic ex_hit, logic ex_is_load,
                                             logic is_branch, logic mem_hit);
    if (stall)                              return SEL_REGFILE;
    if (ex_hit && !ex_is_load && !is_branch) return SEL_EX_ALU;
    if (ex_hit)                             return SEL_REGFILE;
    if (mem_hit)                            return SEL_MEM_WB;
    return SEL_REGFILE;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ex_next   = '0;

    w_live      = bus.id_valid && !bus.id_flush;
    w_m1        = w_live && bus.id_uses_rs1;
    w_m2        = w_live && bus.id_uses_rs2;

    w_ex_hit_a  = w_m1 && is_producer(r_ex,  bus.id_rs1);
    w_ex_hit_b  = w_m2 && is_producer(r_ex,  bus.id_rs2);
    w_mem_hit_a = w_m1 && is_producer(r_mem, bus.id_rs1);
    w_mem_hit_b = w_m2 && is_producer(r_mem, bus.id_rs2);

    w_stall     = w_live && bus.id_is_branch && (w_ex_hit_a || w_ex_hit_b);

    w_sel_a     = operand_sel(w_stall, w_ex_hit_a, r_ex.mem_read, bus.id_is_branch, w_mem_hit_a);
    w_sel_b     = operand_sel(w_stall, w_ex_hit_b, r_ex.mem_read, bus.id_is_branch, w_mem_hit_b);

    if (w_live && !w_stall) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.rd        = bus.id_rd;
      w_ex_next.reg_write = bus.id_reg_write;
      w_ex_next.mem_read  = bus.id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: only the valid bits carry meaning after reset; the whole entry is cleared
      // anyway because it is a handful of flops and keeps rd free of X in simulation.
      r_ex    <= '0;
      r_mem   <= '0;
      r_fwd_a <= 1'b0;
      r_fwd_b <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let r_mem capture the old r_ex in the same edge.
      r_mem   <= r_ex;
      r_ex    <= w_ex_next;
      r_fwd_a <= w_ex_hit_a && !w_stall && r_ex.mem_read;
      r_fwd_b <= w_ex_hit_b && !w_stall && r_ex.mem_read;
    end
  end

  assign bus.stall                = w_stall;
  assign bus.id_fwd_a_sel         = w_sel_a;
  assign bus.id_fwd_b_sel         = w_sel_b;
  assign bus.is_MEM_forward_ALU_A = r_fwd_a;
  assign bus.is_MEM_forward_ALU_B = r_fwd_b;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios followed by random
// instruction streams, compared against a queue-based model of which instruction sits where.
module tb_hazard_forward_unit;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_ADDR_WIDTH(W)) bus ();

  hazard_forward_unit #(.REG_ADDR_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         valid;
    bit         flush;
    bit [W-1:0] rs1;
    bit [W-1:0] rs2;
    bit         u1;
    bit         u2;
    bit         br;
    bit [W-1:0] rd;
    bit         rw;
    bit         mr;
  } instr_t;

  typedef struct {
    bit         valid;
    bit [W-1:0] rd;
    bit         rw;
    bit         mr;
  } slot_t;

  // pipe[0] is the instruction now in EX, pipe[1] the one in MEM.
  slot_t  pipe[$];
  instr_t cur;
  bit     m_fwd_a, m_fwd_b;
  bit     m_stall, m_next_fa, m_next_fb;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic slot_t bubble();
    slot_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit writes(slot_t s, bit [W-1:0] r);
    return s.valid && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic bit [1:0] src_of(bit st, bit ex, bit mem);
    if (st)  return 2'd0;
    if (ex)  return (pipe[0].mr || cur.br) ? 2'd0 : 2'd1;
    if (mem) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    pipe    = '{bubble(), bubble()};
    m_fwd_a = 0;
    m_fwd_b = 0;
  endtask

  // Present an instruction in ID and check every output against the model.
  task automatic drive(input instr_t i);
    bit live, e1, e2, q1, q2;
    bit [1:0] sa, sb;
    cur = i;
    bus.id_valid     = i.valid;
    bus.id_flush     = i.flush;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_uses_rs1  = i.u1;
    bus.id_uses_rs2  = i.u2;
    bus.id_is_branch = i.br;
    bus.id_rd        = i.rd;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.mr;
    #2;
    live      = i.valid && !i.flush;
    e1        = live && i.u1 && writes(pipe[0], i.rs1);
    e2        = live && i.u2 && writes(pipe[0], i.rs2);
    q1        = live && i.u1 && writes(pipe[1], i.rs1);
    q2        = live && i.u2 && writes(pipe[1], i.rs2);
    m_stall   = live && i.br && (e1 || e2);
    sa        = src_of(m_stall, e1, q1);
    sb        = src_of(m_stall, e2, q2);
    m_next_fa = e1 && pipe[0].mr && !m_stall;
    m_next_fb = e2 && pipe[0].mr && !m_stall;
    check("stall", {1'b0, bus.stall}, {1'b0, m_stall});
    check("sel_a", bus.id_fwd_a_sel, sa);
    check("sel_b", bus.id_fwd_b_sel, sb);
    check("memfwd_a", {1'b0, bus.is_MEM_forward_ALU_A}, {1'b0, m_fwd_a});
    check("memfwd_b", {1'b0, bus.is_MEM_forward_ALU_B}, {1'b0, m_fwd_b});
  endtask

  task automatic clock();
    slot_t s;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_fwd_a = m_next_fa;
      m_fwd_b = m_next_fb;
      s = bubble();
      if (cur.valid && !cur.flush && !m_stall) begin
        s.valid = 1;
        s.rd    = cur.rd;
        s.rw    = cur.rw;
        s.mr    = cur.mr;
      end
      pipe.push_front(s);
      void'(pipe.pop_back());
    end
    @(negedge clk);
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic instr_t alu(int rd, int rs1, int rs2);
    instr_t i;
    i = nop();
    i.valid = 1; i.u1 = 1; i.u2 = 1; i.rw = 1;
    i.rd = W'(rd); i.rs1 = W'(rs1); i.rs2 = W'(rs2);
    return i;
  endfunction

  function automatic instr_t imm_op(int rd, int rs1, int rs2_field);
    instr_t i;
    i = alu(rd, rs1, rs2_field);
    i.u2 = 0;
    return i;
  endfunction

  function automatic instr_t load(int rd, int rs1);
    instr_t i;
    i = imm_op(rd, rs1, 0);
    i.mr = 1;
    return i;
  endfunction

  function automatic instr_t branch(int rs1, int rs2);
    instr_t i;
    i = alu(0, rs1, rs2);
    i.rw = 0; i.br = 1;
    return i;
  endfunction

  initial begin
    instr_t r;
    rst_n = 0;
    bus.id_valid = 0; bus.id_flush = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_is_branch = 0;
    bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    model_reset();
    cur = nop();
    @(posedge clk);
    @(negedge clk);
    drive(nop());
    clock();
    rst_n = 1;

    // lw x5 ; add x6,x5,x7 -> no stall, EX-stage load forward on A only
    drive(load(5, 1));              clock();
    drive(alu(6, 5, 7));
    check("lw_add_stall", {1'b0, bus.stall}, 2'd0);
    clock();
    drive(nop());
    check("lw_add_fwd_a", {1'b0, bus.is_MEM_forward_ALU_A}, 2'd1);
    check("lw_add_fwd_b", {1'b0, bus.is_MEM_forward_ALU_B}, 2'd0);
    clock();

    // add x5 ; sub x8,x9,x5 -> B bypassed from EX ALU result
    drive(alu(5, 1, 2));            clock();
    drive(alu(8, 9, 5));
    check("add_sub_sel_b", bus.id_fwd_b_sel, 2'd1);
    check("add_sub_sel_a", bus.id_fwd_a_sel, 2'd0);
    clock();
    drive(nop());
    check("add_sub_nofwd", {bus.is_MEM_forward_ALU_A, bus.is_MEM_forward_ALU_B}, 2'd0);
    clock();

    // lw x5 ; beq x5,x0 -> one bubble, then MEM writeback bypass
    drive(load(5, 2));              clock();
    drive(branch(5, 0));
    check("lw_beq_stall", {1'b0, bus.stall}, 2'd1);
    check("lw_beq_sel_stalled", bus.id_fwd_a_sel, 2'd0);
    clock();
    drive(branch(5, 0));
    check("lw_beq_stall_released", {1'b0, bus.stall}, 2'd0);
    check("lw_beq_sel_a_mem", bus.id_fwd_a_sel, 2'd2);
    clock();

    // x0 writers and an immediate operand never hazard
    drive(alu(0, 1, 2));            clock();
    drive(alu(1, 0, 0));
    check("x0_sels", {bus.id_fwd_a_sel, bus.id_fwd_b_sel}, 4'd0);
    clock();
    drive(alu(7, 3, 4));            clock();
    drive(imm_op(8, 3, 7));
    check("imm_sel_b", bus.id_fwd_b_sel, 2'd0);
    check("imm_stall", {1'b0, bus.stall}, 2'd0);
    clock();

    // add x5 ; add x5 ; add x6,x5,x5 -> EX beats MEM on both operands
    drive(alu(5, 1, 2));            clock();
    drive(alu(5, 3, 4));            clock();
    drive(alu(6, 5, 5));
    check("ex_over_mem_a", bus.id_fwd_a_sel, 2'd1);
    check("ex_over_mem_b", bus.id_fwd_b_sel, 2'd1);
    clock();

    // flushed branch with a pending hazard -> no stall, bubble enters EX
    drive(alu(9, 1, 2));            clock();
    r = branch(9, 9);
    r.flush = 1;
    drive(r);
    check("flush_stall", {1'b0, bus.stall}, 2'd0);
    clock();
    drive(alu(10, 9, 1));
    check("flush_bubble_sel_a", bus.id_fwd_a_sel, 2'd2);
    clock();

    // reset asserted mid-stall
    drive(load(5, 1));              clock();
    drive(branch(5, 6));
    check("rst_pre_stall", {1'b0, bus.stall}, 2'd1);
    rst_n = 0;
    clock();
    rst_n = 1;
    drive(branch(5, 6));
    check("rst_stall", {1'b0, bus.stall}, 2'd0);
    check("rst_sel_a", bus.id_fwd_a_sel, 2'd0);
    check("rst_fwd", {bus.is_MEM_forward_ALU_A, bus.is_MEM_forward_ALU_B}, 2'd0);
    clock();

    // random instruction streams over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0:       r = alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        1:       r = load($urandom_range(0, 7), $urandom_range(0, 7));
        2:       r = branch($urandom_range(0, 7), $urandom_range(0, 7));
        3:       r = imm_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        default: r = nop();
      endcase
      if ($urandom_range(0, 7) == 0) r.valid = 0;
      if ($urandom_range(0, 7) == 0) r.flush = 1;
      drive(r);
      if ($urandom_range(0, 63) == 0) rst_n = 0;
      clock();
      rst_n = 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
